// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Upstream producer for the Sobel edge stage. Accepts a raster-order pixel
//   stream, keeps the two previous rows in line buffers and presents every
//   complete 3x3 neighbourhood on nine registered taps.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pix_in     input pixel (DATA_W bits)
//   pix_valid  pix_in is consumed this cycle
//   sof        start of frame, qualified by pix_valid; forces (row 0, col 0)
//   p00..p22   window taps, row index = image row r-2..r, col index = c-2..c
//   win_valid  taps hold a complete window this cycle
//   win_row    centre row of the window (r-1)
//   win_col    centre column of the window (c-1)
//   eof_out    pulses with the last window of a frame
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [DATA_W-1:0]             p00,
    output logic [DATA_W-1:0]             p01,
    output logic [DATA_W-1:0]             p02,
    output logic [DATA_W-1:0]             p10,
    output logic [DATA_W-1:0]             p11,
    output logic [DATA_W-1:0]             p12,
    output logic [DATA_W-1:0]             p20,
    output logic [DATA_W-1:0]             p21,
    output logic [DATA_W-1:0]             p22,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          eof_out
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] TWO_C  = CW'(2);
    localparam logic [RW-1:0] TWO_R  = RW'(2);

    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [CW-1:0]     cur_c;
    logic [RW-1:0]     cur_r;

    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_rd;
    logic [DATA_W-1:0] lb2_rd;

    logic              win_ok;
    logic              frame_end;

    // Coordinates of the pixel presented this cycle; sof realigns to (0,0)
    // combinationally so the sof pixel itself lands in column 0 of the buffers.
    always_comb begin
        cur_c     = sof ? '0 : col_cnt;
        cur_r     = sof ? '0 : row_cnt;
        lb1_rd    = lb1[cur_c];
        lb2_rd    = lb2[cur_c];
        win_ok    = (cur_r >= TWO_R) && (cur_c >= TWO_C);
        frame_end = (cur_r == LAST_R) && (cur_c == LAST_C);
    end

    // Raster position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pix_valid) begin
            if (cur_c == LAST_C) begin
                col_cnt <= '0;
                row_cnt <= (cur_r == LAST_R) ? '0 : cur_r + 1'b1;
            end else begin
                col_cnt <= cur_c + 1'b1;
                row_cnt <= cur_r;
            end
        end
    end

    // Line buffers: no reset, rows 0 and 1 of every frame overwrite them
    // before a window can use them. Reads above see pre-write contents.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2[cur_c] <= lb1_rd;
            lb1[cur_c] <= pix_in;
        end
    end

    // Tap window, strobes and centre coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p00       <= '0;
            p01       <= '0;
            p02       <= '0;
            p10       <= '0;
            p11       <= '0;
            p12       <= '0;
            p20       <= '0;
            p21       <= '0;
            p22       <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            eof_out   <= 1'b0;
        end else if (pix_valid) begin
            p00       <= p01;
            p01       <= p02;
            p02       <= lb2_rd;
            p10       <= p11;
            p11       <= p12;
            p12       <= lb1_rd;
            p20       <= p21;
            p21       <= p22;
            p22       <= pix_in;
            win_valid <= win_ok;
            win_row   <= cur_r - 1'b1;
            win_col   <= cur_c - 1'b1;
            eof_out   <= win_ok && frame_end;
        end else begin
            win_valid <= 1'b0;
            eof_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       sof;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic       win_valid;
    logic [1:0] win_row;
    logic [2:0] win_col;
    logic       eof_out;

    sobel_window_gen #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_in   (pix_in),
        .pix_valid(pix_valid),
        .sof      (sof),
        .p00(p00), .p01(p01), .p02(p02),
        .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22),
        .win_valid(win_valid),
        .win_row  (win_row),
        .win_col  (win_col),
        .eof_out  (eof_out)
    );

    always #5 clk = ~clk;

    logic [71:0] taps_act;
    assign taps_act = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

    typedef struct {
        logic [71:0] taps;
        logic [1:0]  row;
        logic [2:0]  col;
        logic        eof;
    } win_t;

    typedef struct {
        int base0;
        int base1;
        int nframes;
        int idle_pct;
        int exp_win;
        int exp_eof;
        int f1_p00;
        int f1_p22;
        int f2_p00;
        int f2_p22;
    } scen_t;

    win_t        sb[$];
    logic [7:0]  seen_p00[$];
    logic [7:0]  seen_p22[$];
    int          total = 0;
    int          bad = 0;
    int          nwin = 0;
    int          neof = 0;
    bit          have_last = 0;
    logic [71:0] last_taps;

    function automatic logic [7:0] pv(int base, int r, int c);
        return 8'(base + 10 * r + c);
    endfunction

    function automatic win_t model(int base, int r, int c);
        win_t w;
        w.taps = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w.taps = (w.taps << 8) | 72'(pv(base, r - 2 + i, c - 2 + j));
        w.row = 2'(r - 1);
        w.col = 3'(c - 1);
        w.eof = (r == H - 1) && (c == W - 1);
        return w;
    endfunction

    task automatic check_cycle(input bit acc);
        win_t w;
        @(posedge clk);
        #1;
        total++;
        if (win_valid !== (sb.size() != 0)) begin
            bad++;
            $display("FAIL win_valid act=%0b exp=%0b", win_valid, sb.size() != 0);
        end
        if (sb.size() != 0) begin
            w = sb.pop_front();
            if (win_valid === 1'b1) begin
                total++;
                if (taps_act !== w.taps) begin
                    bad++;
                    $display("FAIL taps act=%h exp=%h", taps_act, w.taps);
                end
                total++;
                if (win_row !== w.row || win_col !== w.col) begin
                    bad++;
                    $display("FAIL centre act=(%0d,%0d) exp=(%0d,%0d)", win_row, win_col, w.row, w.col);
                end
                total++;
                if (eof_out !== w.eof) begin
                    bad++;
                    $display("FAIL eof_win act=%0b exp=%0b", eof_out, w.eof);
                end
                seen_p00.push_back(p00);
                seen_p22.push_back(p22);
                nwin++;
                if (eof_out === 1'b1) neof++;
                last_taps = w.taps;
                have_last = 1;
            end else begin
                have_last = 0;
            end
        end else begin
            total++;
            if (eof_out !== 1'b0) begin
                bad++;
                $display("FAIL eof_nowin act=%0b exp=0", eof_out);
            end
            if (acc) begin
                have_last = 0;
            end else if (have_last) begin
                total++;
                if (taps_act !== last_taps) begin
                    bad++;
                    $display("FAIL taps_hold act=%h exp=%h", taps_act, last_taps);
                end
            end
        end
        sb.delete();
    endtask

    task automatic drive_pix(input int base, input int r, input int c, input bit s);
        pix_in    = pv(base, r, c);
        pix_valid = 1'b1;
        sof       = s;
        if (r >= 2 && c >= 2) sb.push_back(model(base, r, c));
        check_cycle(1'b1);
    endtask

    // Idle cycles carry junk data and a random sof, all of which must be ignored.
    task automatic idle();
        pix_in    = 8'($urandom);
        pix_valid = 1'b0;
        sof       = 1'($urandom_range(0, 1));
        check_cycle(1'b0);
    endtask

    task automatic send_frame(input int base, input bit sof_first, input int idle_pct, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            int n = 0;
            while (idle_pct > 0 && n < 4 && $urandom_range(0, 99) < idle_pct) begin
                idle();
                n++;
            end
            drive_pix(base, idx / W, idx % W, sof_first && idx == 0);
        end
    endtask

    task automatic clear_log();
        nwin = 0;
        neof = 0;
        seen_p00.delete();
        seen_p22.delete();
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({taps_act, win_valid, win_row, win_col, eof_out} !== '0) begin
            bad++;
            $display("FAIL %s taps=%h v=%0b row=%0d col=%0d eof=%0b exp=all0",
                     name, taps_act, win_valid, win_row, win_col, eof_out);
        end
    endtask

    scen_t tbl[3];

    initial begin
        tbl[0] = '{base0: 0, base1: 0,  nframes: 1, idle_pct: 0,  exp_win: 6,  exp_eof: 1,
                   f1_p00: 0, f1_p22: 22, f2_p00: 0,  f2_p22: 0};
        tbl[1] = '{base0: 0, base1: 0,  nframes: 1, idle_pct: 40, exp_win: 6,  exp_eof: 1,
                   f1_p00: 0, f1_p22: 22, f2_p00: 0,  f2_p22: 0};
        tbl[2] = '{base0: 0, base1: 50, nframes: 2, idle_pct: 0,  exp_win: 12, exp_eof: 2,
                   f1_p00: 0, f1_p22: 22, f2_p00: 50, f2_p22: 72};

        rst_n     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;

        for (int s = 0; s < 3; s++) begin
            clear_log();
            send_frame(tbl[s].base0, 1'b1, tbl[s].idle_pct, W * H);
            if (tbl[s].nframes == 2) send_frame(tbl[s].base1, 1'b0, tbl[s].idle_pct, W * H);
            repeat (3) idle();
            check_int($sformatf("s%0d_nwin", s), nwin, tbl[s].exp_win);
            check_int($sformatf("s%0d_neof", s), neof, tbl[s].exp_eof);
            if (nwin > 0) begin
                check_int($sformatf("s%0d_f1_p00", s), int'(seen_p00[0]), tbl[s].f1_p00);
                check_int($sformatf("s%0d_f1_p22", s), int'(seen_p22[0]), tbl[s].f1_p22);
                check_int($sformatf("s%0d_last_p22", s), int'(seen_p22[nwin-1]),
                          (tbl[s].nframes == 2 ? tbl[s].base1 : tbl[s].base0) + 34);
            end
            if (tbl[s].nframes == 2 && nwin > 6) begin
                check_int($sformatf("s%0d_f2_p00", s), int'(seen_p00[6]), tbl[s].f2_p00);
                check_int($sformatf("s%0d_f2_p22", s), int'(seen_p22[6]), tbl[s].f2_p22);
            end
        end

        // sof reasserted part way into a frame.
        clear_log();
        send_frame(0, 1'b1, 0, 7);
        send_frame(100, 1'b1, 0, W * H);
        repeat (2) idle();
        check_int("realign_nwin", nwin, 6);
        if (nwin > 0) begin
            check_int("realign_p00", int'(seen_p00[0]), 100);
            check_int("realign_p22", int'(seen_p22[0]), 122);
        end

        // Asynchronous reset during row 2, then a frame without sof.
        clear_log();
        send_frame(0, 1'b1, 0, 13);
        pix_valid = 1'b0;
        sof       = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        have_last = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        send_frame(0, 1'b0, 0, W * H);
        repeat (2) idle();
        check_int("post_reset_nwin", nwin, 6);
        check_int("post_reset_neof", neof, 1);
        if (nwin > 0) begin
            check_int("post_reset_p00", int'(seen_p00[0]), 0);
            check_int("post_reset_p22", int'(seen_p22[0]), 22);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
